// File: rtl/seq101_pattern_tx.sv
// Serial "101" pattern transmitter: shifts handshaked words out MSB-first with an optional
// repeat count, and runs a golden model of the overlapping Mealy "101" detector alongside.
module seq101_pattern_tx #(
    parameter int   WIDTH    = 8,
    parameter int   REP_W    = 4,
    parameter int   COUNT_W  = 16,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [REP_W-1:0]   in_repeat,
    input  logic               cnt_clear,
    output logic               tx_bit,
    output logic               tx_active,
    output logic               frame_done,
    output logic               expect_detect,
    output logic [COUNT_W-1:0] detect_count
);

    localparam int BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [1:0]         hist_q, hist_d;
    logic [COUNT_W-1:0] detect_count_q, detect_count_d;

    logic last_bit;
    logic accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            word_q         <= '0;
            bit_cnt_q      <= '0;
            rep_cnt_q      <= '0;
            hist_q         <= 2'b00;
            detect_count_q <= '0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            word_q         <= word_d;
            bit_cnt_q      <= bit_cnt_d;
            rep_cnt_q      <= rep_cnt_d;
            hist_q         <= hist_d;
            detect_count_q <= detect_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        word_d         = word_q;
        bit_cnt_d      = bit_cnt_q;
        rep_cnt_d      = rep_cnt_q;
        detect_count_d = detect_count_q;

        last_bit   = (state_q == SHIFT) && (bit_cnt_q == '0) && (rep_cnt_q == '0);
        in_ready   = !reset && ((state_q == IDLE) || last_bit);
        accept     = in_valid && in_ready;
        tx_active  = (state_q == SHIFT);
        tx_bit     = (state_q == SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
        frame_done = last_bit;

        // hist == 2'b10 is the detector's "saw 10" state; a 1 now completes the pattern
        expect_detect = (hist_q == 2'b10) && tx_bit;
        hist_d        = {hist_q[0], tx_bit};

        if (state_q == SHIFT) begin
            if (bit_cnt_q != '0) begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
            end else if (rep_cnt_q != '0) begin
                shreg_d   = word_q;
                bit_cnt_d = LAST_IDX;
                rep_cnt_d = rep_cnt_q - 1'b1;
            end else if (!accept) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            state_d   = SHIFT;
            shreg_d   = in_data;
            word_d    = in_data;
            bit_cnt_d = LAST_IDX;
            rep_cnt_d = in_repeat;
        end

        if (cnt_clear) begin
            detect_count_d = '0;
        end else if (expect_detect && (detect_count_q != '1)) begin
            detect_count_d = detect_count_q + 1'b1;
        end
    end

    assign detect_count = detect_count_q;

endmodule

// File: tb/tb_seq101_pattern_tx.sv
// Self-checking bench for seq101_pattern_tx: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-of-pending-bits reference model.
module tb_seq101_pattern_tx;

    localparam int   WIDTH    = 8;
    localparam int   REP_W    = 4;
    localparam int   COUNT_W  = 4;
    localparam logic IDLE_BIT = 1'b0;
    localparam int   CNT_MAX  = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [REP_W-1:0]   in_repeat;
    logic               cnt_clear;
    logic               tx_bit;
    logic               tx_active;
    logic               frame_done;
    logic               expect_detect;
    logic [COUNT_W-1:0] detect_count;

    seq101_pattern_tx #(
        .WIDTH(WIDTH), .REP_W(REP_W), .COUNT_W(COUNT_W), .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_repeat(in_repeat), .cnt_clear(cnt_clear),
        .tx_bit(tx_bit), .tx_active(tx_active), .frame_done(frame_done),
        .expect_detect(expect_detect), .detect_count(detect_count)
    );

    always #5 clk = ~clk;

    // Reference model: every bit still to be sent sits in a queue, tagged if it ends a frame
    typedef struct packed {
        logic b;
        logic last;
    } pend_t;

    pend_t pend_q[$];
    int    prev1, prev2, model_cnt;
    int    checks = 0;
    int    errors = 0;
    bit    clear_on_detect = 0;
    bit    last_accept;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        pend_q.delete();
        prev1 = 0;
        prev2 = 0;
        model_cnt = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model at the edge
    task automatic applyStimulus(input logic rst, input logic valid, input logic [WIDTH-1:0] data,
                                 input logic [REP_W-1:0] rep, input logic clr);
        int  exp_bit, exp_active, exp_done, exp_det, exp_ready;
        logic clr_eff;
        exp_active = (pend_q.size() > 0);
        exp_bit    = exp_active ? int'(pend_q[0].b) : int'(IDLE_BIT);
        exp_done   = exp_active ? int'(pend_q[0].last) : 0;
        exp_det    = (prev2 == 1 && prev1 == 0 && exp_bit == 1);
        exp_ready  = (!rst && pend_q.size() <= 1);
        clr_eff    = clr;
        if (clear_on_detect && exp_det == 1) begin
            clr_eff = 1'b1;
            clear_on_detect = 0;
        end
        reset     = rst;
        in_valid  = valid;
        in_data   = data;
        in_repeat = rep;
        cnt_clear = clr_eff;
        #1;
        checkOutput("tx_bit",        int'(tx_bit),        exp_bit);
        checkOutput("tx_active",     int'(tx_active),     exp_active);
        checkOutput("frame_done",    int'(frame_done),    exp_done);
        checkOutput("expect_detect", int'(expect_detect), exp_det);
        checkOutput("in_ready",      int'(in_ready),      exp_ready);
        checkOutput("detect_count",  int'(detect_count),  model_cnt);
        last_accept = valid && (exp_ready == 1);
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            prev2 = prev1;
            prev1 = exp_bit;
            if (clr_eff) model_cnt = 0;
            else if (exp_det == 1 && model_cnt < CNT_MAX) model_cnt++;
            if (pend_q.size() > 0) void'(pend_q.pop_front());
            if (last_accept) begin
                for (int r = 0; r <= int'(rep); r++)
                    for (int i = WIDTH - 1; i >= 0; i--)
                        pend_q.push_back('{b: data[i], last: (r == int'(rep) && i == 0)});
            end
        end
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic resetCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_repeat = '0; cnt_clear = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("[TB] basic word");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b1010_0101, 4'd0, 1'b0);
        idleCycles(10);
        checkOutput("basic_count", int'(detect_count), 2);

        $display("[TB] overlap");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b1010_1010, 4'd0, 1'b0);
        idleCycles(10);
        checkOutput("overlap_count", int'(detect_count), 3);

        $display("[TB] repeat");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b0000_0101, 4'd1, 1'b0);
        idleCycles(18);
        checkOutput("repeat_count", int'(detect_count), 2);

        $display("[TB] back-to-back");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b0000_0010, 4'd0, 1'b0);
        last_accept = 0;
        for (int k = 0; k < 20 && !last_accept; k++)
            applyStimulus(1'b0, 1'b1, 8'b1000_0000, 4'd0, 1'b0);
        checkOutput("b2b_accepted", int'(last_accept), 1);
        idleCycles(10);
        checkOutput("b2b_count", int'(detect_count), 1);

        $display("[TB] idle gap");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b0000_0010, 4'd0, 1'b0);
        idleCycles(11);
        applyStimulus(1'b0, 1'b1, 8'b1000_0000, 4'd0, 1'b0);
        idleCycles(10);
        checkOutput("gap_count", int'(detect_count), 0);

        $display("[TB] reset mid-frame");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b1010_0101, 4'd0, 1'b0);
        idleCycles(3);
        resetCycles(1);
        checkOutput("midrst_active", int'(tx_active), 0);
        checkOutput("midrst_done", int'(frame_done), 0);
        idleCycles(3);

        $display("[TB] saturation and clear");
        resetCycles(1);
        applyStimulus(1'b0, 1'b1, 8'b1010_1010, 4'd4, 1'b0);
        idleCycles(44);
        checkOutput("sat_count", int'(detect_count), CNT_MAX);
        clear_on_detect = 1;
        applyStimulus(1'b0, 1'b1, 8'b1010_1010, 4'd0, 1'b0);
        idleCycles(3);
        checkOutput("clear_count", int'(detect_count), 0);
        idleCycles(8);
        checkOutput("after_clear_count", int'(detect_count), 2);

        $display("[TB] random traffic");
        resetCycles(1);
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 1) == 1),
                          WIDTH'($urandom),
                          REP_W'($urandom_range(0, 3)),
                          ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
